// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan controller: blank patterns and the
// hex-to-segment lookup (gfedcba, active low).
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Entry 0 sits at the LSB end, so HEX_SEG[n] is the pattern for nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_to_seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode scan controller with per-slot ghost blanking and a
// double-buffered display value that only swaps at the frame boundary.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blank_mask,
  input  logic        load,
  output logic        busy,
  output logic        frame_tick,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_TICKS);

  logic [CW-1:0] cnt;
  digit_idx_t    idx;

  logic [15:0] disp_value, pend_value;
  logic [3:0]  disp_dp, pend_dp;
  logic [3:0]  disp_blank, pend_blank;

  logic        boundary;
  logic        lit;
  logic [3:0]  cur_nib;
  logic [6:0]  dec_seg;
  logic [3:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_next;

  assign boundary = (cnt == CNT_LAST) && (idx == 2'd3);
  assign cur_nib  = disp_value[{idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    lit      = (cnt >= CNT_BLANK) && !disp_blank[idx];
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (lit) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = dec_seg;
      dp_next  = ~disp_dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load landing on the boundary itself bypasses the pending buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      busy       <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        disp_value <= value;
        disp_dp    <= dp_mask;
        disp_blank <= blank_mask;
      end else if (busy) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
      busy <= 1'b0;
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp_mask;
      pend_blank <= blank_mask;
      busy       <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random loads, checked
// cycle by cycle against a frame-position model of the display.
module tb_seven_seg_scan_ctrl;

  localparam int T = 8;
  localparam int B = 2;
  localparam int F = 4 * T;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic        load = 1'b0;
  logic        busy, frame_tick, dp;
  logic [3:0]  an;
  logic [6:0]  seg;

  seven_seg_scan_ctrl #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .load       (load),
    .busy       (busy),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: position within the 32-cycle frame plus shown and pending contents.
  int          pos;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_bl, p_dp, p_bl;
  logic        m_busy;

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    m_val = '0; m_dp = '0; m_bl = '0;
    p_val = '0; p_dp = '0; p_bl = '0;
    m_busy = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dm, input logic [3:0] bm);
    int d, c;
    logic on;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed, eft;
    @(negedge clk);
    load = ld; value = v; dp_mask = dm; blank_mask = bm;
    c  = pos % T;
    d  = pos / T;
    on = (c >= B) && !m_bl[d];
    ea = on ? ~(4'b0001 << d) : 4'b1111;
    es = on ? tbl[m_val[d*4 +: 4]] : 7'b1111111;
    ed = on ? ~m_dp[d] : 1'b1;
    eft = (pos == F - 1);
    if (pos == F - 1) begin
      if (ld) begin
        m_val = v; m_dp = dm; m_bl = bm;
      end else if (m_busy) begin
        m_val = p_val; m_dp = p_dp; m_bl = p_bl;
      end
      m_busy = 1'b0;
    end else if (ld) begin
      p_val = v; p_dp = dm; p_bl = bm;
      m_busy = 1'b1;
    end
    pos = (pos + 1) % F;
    @(posedge clk);
    #1;
    check("an", an, ea);
    check("seg", seg, es);
    check("dp", dp, ed);
    check("busy", busy, m_busy);
    check("frame_tick", frame_tick, eft);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic run_to_boundary();
    while (pos != F - 1) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, an, 4'b1111);
    check({tag, "_seg"}, seg, 7'b1111111);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ft"}, frame_tick, 1'b0);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk);
    #2 rst = 1'b0;

    idle(40);

    // 1234: busy until the boundary, then digits 4,3,2,1 in the next frame.
    step(1'b1, 16'h1234, 4'b0000, 4'b0000);
    idle(70);

    step(1'b1, 16'hBD00, 4'b0000, 4'b0000);
    idle(70);

    step(1'b1, 16'h8888, 4'b0001, 4'b1000);
    idle(70);

    // Two loads in one frame: only the later one reaches the display.
    run_to_boundary();
    idle(3);
    step(1'b1, 16'hAAAA, 4'b1010, 4'b0000);
    idle(6);
    step(1'b1, 16'h5555, 4'b0101, 4'b0000);
    idle(70);

    // Load on the boundary cycle goes straight to the display.
    step(1'b1, 16'h0123, 4'b0000, 4'b0000);
    run_to_boundary();
    step(1'b1, 16'hFFFF, 4'b0000, 4'b0000);
    idle(40);

    // Mid-scan reset with an update pending: pending is lost, scan restarts.
    idle(13);
    step(1'b1, 16'h9876, 4'b1111, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1 check_reset_outputs("midrst_hold");
    #1 rst = 1'b0;
    idle(70);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
